// File: rtl/shot_resolver_if.sv
`timescale 1ns/1ps
// shot_resolver_if: the VGA pixel-plot bus shared by the bird/hunter draw FSM,
// the VGA adapter and the shot resolver. The draw FSM is the master; every
// snooper (adapter, resolver) only ever listens through the slave view.
interface shot_resolver_if;
   logic       frame_start;  // one-cycle pulse at the start of each draw frame
   logic       plot;         // pixel write strobe
   logic [7:0] x;            // plotted pixel x
   logic [6:0] y;            // plotted pixel y
   logic [2:0] colour;       // plotted colour, 3'b000 = erase
   logic [2:0] src_id;       // object currently being drawn, 7 = hunter/none

   modport master (output frame_start, plot, x, y, colour, src_id);
   modport slave  (input  frame_start, plot, x, y, colour, src_id);
endinterface

// File: rtl/shot_resolver.sv
`timescale 1ns/1ps
// shot_resolver: on a fire request, latches the crosshair, snoops one full draw
// frame on the plot bus and reports the first live bird that painted a visible
// pixel under the crosshair. Hits set sticky kill flags and bump a saturating
// score.
// Build option: define SHOT_WINDOW_EN for a 3x3 aim window around the crosshair;
// left undefined, only the exact crosshair pixel counts.
module shot_resolver #(
   parameter int NUM_BIRDS = 7,
   parameter int SCORE_W   = 8
) (
   input  logic                 clock,
   input  logic                 resetn,
   shot_resolver_if.slave       bus,
   input  logic                 fire,
   input  logic [7:0]           aim_x,
   input  logic [6:0]           aim_y,
   input  logic                 clear_kills,
   output logic                 busy,
   output logic                 hit,
   output logic                 miss,
   output logic [2:0]           hit_id,
   output logic [NUM_BIRDS-1:0] kill_mask,
   output logic [SCORE_W-1:0]   score
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SCAN, S_RESOLVE} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [7:0]           r_aim_x;
   logic [6:0]           r_aim_y;
   logic                 r_cand_valid;
   logic [2:0]           r_cand_id;
   logic                 r_busy;
   logic                 r_hit;
   logic                 r_miss;
   logic [2:0]           r_hit_id;
   logic [NUM_BIRDS-1:0] r_kill_mask;
   logic [SCORE_W-1:0]   r_score;

   logic                 w_accept;
   logic                 w_close;
   logic                 w_in_window;
   logic                 w_live_bird;
   logic                 w_match;
   logic                 w_final_valid;
   logic [2:0]           w_final_id;
   logic [NUM_BIRDS-1:0] w_src_onehot;
   logic [NUM_BIRDS-1:0] w_final_onehot;

`ifdef SHOT_WINDOW_EN
   // Zero-extended signed differences: the window never wraps across the
   // screen edge, so aim_x=0 does not reach pixel x=159.
   logic signed [8:0] w_dx;
   logic signed [7:0] w_dy;
   assign w_dx        = $signed({1'b0, bus.x}) - $signed({1'b0, r_aim_x});
   assign w_dy        = $signed({1'b0, bus.y}) - $signed({1'b0, r_aim_y});
   assign w_in_window = (w_dx >= -9'sd1) && (w_dx <= 9'sd1) &&
                        (w_dy >= -8'sd1) && (w_dy <= 8'sd1);
`else
   assign w_in_window = (bus.x == r_aim_x) && (bus.y == r_aim_y);
`endif

   // Ids at or above NUM_BIRDS (the hunter) shift out to an all-zero one-hot,
   // so they can never look like a live bird.
   assign w_src_onehot   = NUM_BIRDS'(1) << bus.src_id;
   assign w_live_bird    = |(w_src_onehot & ~r_kill_mask);
   assign w_match        = bus.plot && (bus.colour != 3'b000) && w_live_bird && w_in_window;

   // A match on the closing frame_start cycle still counts if nothing earlier did.
   assign w_final_valid  = r_cand_valid || w_match;
   assign w_final_id     = r_cand_valid ? r_cand_id : bus.src_id;
   assign w_final_onehot = NUM_BIRDS'(1) << w_final_id;

   // Next-state logic; fire is only looked at in IDLE, so fires while busy drop.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_close      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (fire) begin
               w_state_next = S_ARMED;
               w_accept     = 1'b1;
            end
         end
         S_ARMED:   if (bus.frame_start) w_state_next = S_SCAN;
         S_SCAN: begin
            if (bus.frame_start) begin
               w_state_next = S_RESOLVE;
               w_close      = 1'b1;
            end
         end
         S_RESOLVE: w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Crosshair latch and first-match candidate capture.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_aim_x      <= '0;
         r_aim_y      <= '0;
         r_cand_valid <= 1'b0;
         r_cand_id    <= '0;
      end else if (w_accept) begin
         r_aim_x      <= aim_x;
         r_aim_y      <= aim_y;
         r_cand_valid <= 1'b0;
         r_cand_id    <= '0;
      end else if ((r_state == S_SCAN) && w_match && !r_cand_valid) begin
         r_cand_valid <= 1'b1;
         r_cand_id    <= bus.src_id;
      end
   end

   // Registered outputs: result pulses, hit id, kill flags and saturating score.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_busy      <= 1'b0;
         r_hit       <= 1'b0;
         r_miss      <= 1'b0;
         r_hit_id    <= '0;
         r_kill_mask <= '0;
         r_score     <= '0;
      end else begin
         r_busy <= (w_state_next != S_IDLE);
         r_hit  <= w_close && w_final_valid;
         r_miss <= w_close && !w_final_valid;
         if (w_close && w_final_valid) r_hit_id <= w_final_id;
         // A clear coinciding with a hit wins for mask and score; hit still pulses.
         if (clear_kills) begin
            r_kill_mask <= '0;
            r_score     <= '0;
         end else if (w_close && w_final_valid) begin
            r_kill_mask <= r_kill_mask | w_final_onehot;
            if (r_score != '1) r_score <= r_score + SCORE_W'(1);
         end
      end
   end

   assign busy      = r_busy;
   assign hit       = r_hit;
   assign miss      = r_miss;
   assign hit_id    = r_hit_id;
   assign kill_mask = r_kill_mask;
   assign score     = r_score;

endmodule

// File: tb/tb_shot_resolver.sv
`timescale 1ns/1ps
// tb_shot_resolver: directed shots against shot_resolver. Stimulus pushes the
// expected result of each shot into a queue; an independent monitor pops and
// compares whenever the DUT pulses hit or miss. A narrow score (SCORE_W=2)
// lets saturation be reached with the seven available birds.
module tb_shot_resolver;
   localparam int NB = 7;
   localparam int SW = 2;

   logic          clock = 1'b0;
   logic          resetn;
   logic          fire;
   logic          clear_kills;
   logic [7:0]    aim_x;
   logic [6:0]    aim_y;
   logic          busy;
   logic          hit;
   logic          miss;
   logic [2:0]    hit_id;
   logic [NB-1:0] kill_mask;
   logic [SW-1:0] score;

   shot_resolver_if bus();

   shot_resolver #(.NUM_BIRDS(NB), .SCORE_W(SW)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .bus         (bus),
      .fire        (fire),
      .aim_x       (aim_x),
      .aim_y       (aim_y),
      .clear_kills (clear_kills),
      .busy        (busy),
      .hit         (hit),
      .miss        (miss),
      .hit_id      (hit_id),
      .kill_mask   (kill_mask),
      .score       (score)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic          is_hit;
      logic [2:0]    id;
      logic [NB-1:0] mask;
      logic [SW-1:0] score;
   } result_t;

   result_t       exp_q[$];
   result_t       mon_e;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [2:0]    m_id;
   logic [NB-1:0] m_mask;
   logic [SW-1:0] m_score;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Expected-result helpers: update the reference state and queue the result.
   task automatic expect_hit(input logic [2:0] id);
      m_id   = id;
      m_mask = m_mask | (NB'(1) << id);
      if (m_score != '1) m_score = m_score + SW'(1);
      exp_q.push_back('{1'b1, m_id, m_mask, m_score});
   endtask

   task automatic expect_miss();
      exp_q.push_back('{1'b0, m_id, m_mask, m_score});
   endtask

   task automatic expect_clear_hit(input logic [2:0] id);
      m_id    = id;
      m_mask  = '0;
      m_score = '0;
      exp_q.push_back('{1'b1, m_id, m_mask, m_score});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_fire(input logic [7:0] ax, input logic [6:0] ay);
      fire = 1'b1; aim_x = ax; aim_y = ay;
      tick();
      fire = 1'b0;
   endtask

   task automatic do_frame();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic do_plot(input logic [7:0] px, input logic [6:0] py,
                          input logic [2:0] col, input logic [2:0] id);
      bus.plot = 1'b1; bus.x = px; bus.y = py; bus.colour = col; bus.src_id = id;
      tick();
      bus.plot = 1'b0;
   endtask

   // Closing frame, then the RESOLVE cycle; busy must be low afterwards.
   task automatic close_shot();
      do_frame();
      tick();
      check("busy_after_result", 32'(busy), 32'd0);
   endtask

   // Monitor: every hit/miss pulse is matched against the next queued result.
   always @(negedge clock) begin
      if (hit || miss) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: hit=%0b miss=%0b with no result expected", hit, miss);
         end else begin
            mon_e = exp_q.pop_front();
            check("result_hit",  32'(hit),       32'(mon_e.is_hit));
            check("result_miss", 32'(miss),      32'(!mon_e.is_hit));
            check("hit_id",      32'(hit_id),    32'(mon_e.id));
            check("kill_mask",   32'(kill_mask), 32'(mon_e.mask));
            check("score",       32'(score),     32'(mon_e.score));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; fire = 1'b0; clear_kills = 1'b0; aim_x = '0; aim_y = '0;
      bus.frame_start = 1'b0; bus.plot = 1'b0; bus.x = '0; bus.y = '0;
      bus.colour = '0; bus.src_id = '0;
      m_id = '0; m_mask = '0; m_score = '0;

      // Reset state
      repeat (3) tick();
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_hit",       32'(hit),       32'd0);
      check("rst_miss",      32'(miss),      32'd0);
      check("rst_hit_id",    32'(hit_id),    32'd0);
      check("rst_kill_mask", 32'(kill_mask), 32'd0);
      check("rst_score",     32'(score),     32'd0);
      resetn = 1'b1;
      tick();

      // Exact hit on bird 2: hit_id 2, mask 0000100, score 1
      do_fire(8'd50, 7'd20);
      check("busy_rise", 32'(busy), 32'd1);
      do_frame();
      do_plot(8'd50, 7'd20, 3'b111, 3'd2);
      expect_hit(3'd2);
      close_shot();

      // Erase from bird 1 and hunter pixel are both ignored: miss
      do_fire(8'd50, 7'd20);
      do_frame();
      do_plot(8'd50, 7'd20, 3'b000, 3'd1);
      do_plot(8'd50, 7'd20, 3'b001, 3'd7);
      expect_miss();
      close_shot();

      // Killed bird 2 excluded, bird 4 first, bird 5 later ignored
      do_fire(8'd50, 7'd20);
      do_frame();
      do_plot(8'd50, 7'd20, 3'b111, 3'd2);
      do_plot(8'd50, 7'd20, 3'b111, 3'd4);
      do_plot(8'd50, 7'd20, 3'b111, 3'd5);
      expect_hit(3'd4);
      close_shot();

      // Diagonal neighbour of the crosshair: hit only with the 3x3 window
      do_fire(8'd0, 7'd0);
      do_frame();
      do_plot(8'd1, 7'd1, 3'b111, 3'd0);
`ifdef SHOT_WINDOW_EN
      expect_hit(3'd0);
`else
      expect_miss();
`endif
      close_shot();

      // No wrap at the left screen edge
      do_fire(8'd0, 7'd0);
      do_frame();
      do_plot(8'd159, 7'd0, 3'b111, 3'd3);
      expect_miss();
      close_shot();

      // fire with frame_start in the same cycle: that frame_start only arms
      fire = 1'b1; aim_x = 8'd10; aim_y = 7'd10; bus.frame_start = 1'b1;
      tick();
      fire = 1'b0; bus.frame_start = 1'b0;
      check("armed_busy", 32'(busy), 32'd1);
      do_plot(8'd10, 7'd10, 3'b111, 3'd1);     // still ARMED: not a candidate
      do_frame();                              // opens SCAN
      do_fire(8'd20, 7'd20);                   // dropped: aim stays (10,10)
      check("busy_fire_dropped", 32'(busy), 32'd1);
      do_plot(8'd20, 7'd20, 3'b111, 3'd3);
      do_plot(8'd10, 7'd10, 3'b111, 3'd6);
      expect_hit(3'd6);
      close_shot();

      // Match on the closing cycle together with clear_kills: hit, mask/score 0
      do_fire(8'd30, 7'd30);
      do_frame();
      bus.frame_start = 1'b1; clear_kills = 1'b1;
      bus.plot = 1'b1; bus.x = 8'd30; bus.y = 7'd30; bus.colour = 3'b101; bus.src_id = 3'd5;
      expect_clear_hit(3'd5);
      tick();
      bus.frame_start = 1'b0; clear_kills = 1'b0; bus.plot = 1'b0;
      tick();
      check("busy_after_clear_hit", 32'(busy), 32'd0);

      // Five hits in a row: score saturates at 3 (first one matches on the closing cycle)
      for (int i = 0; i < 5; i++) begin
         do_fire(8'(100 + i), 7'd50);
         do_frame();
         if (i == 0) begin
            bus.plot = 1'b1; bus.x = 8'd100; bus.y = 7'd50; bus.colour = 3'b010; bus.src_id = 3'd0;
            expect_hit(3'd0);
            close_shot();
            bus.plot = 1'b0;
         end else begin
            do_plot(8'(100 + i), 7'd50, 3'b010, 3'(i));
            expect_hit(3'(i));
            close_shot();
         end
      end

      // Reset during SCAN with a candidate recorded: no result afterwards
      do_fire(8'd40, 7'd40);
      do_frame();
      do_plot(8'd40, 7'd40, 3'b111, 3'd6);
      resetn = 1'b0;
      #1;
      check("midscan_rst_busy",  32'(busy),      32'd0);
      check("midscan_rst_mask",  32'(kill_mask), 32'd0);
      check("midscan_rst_score", 32'(score),     32'd0);
      #2 resetn = 1'b1;
      do_frame();
      repeat (3) tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_id",   32'(hit_id), 32'd0);

      check("results_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
